// File: rtl/f8_console_pkg.sv
// -----------------------------------------------------------------------------
// f8_console_pkg
// Shared types and constants for the GPIO-to-UART bench console.
//   tx_state_t  : transmitter FSM states (IDLE, START, DATA, STOP)
//   FRAME_BITS  : bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS   : payload bits per frame
// -----------------------------------------------------------------------------
package f8_console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/gpio_uart_console_if.sv
// -----------------------------------------------------------------------------
// gpio_uart_console_if
// Bundles the console's GPIO input side and UART/status output side.
//   gpio_data   : byte to emit (from gpio0pins)
//   gpio_strobe : toggle-type write strobe (from gpio1pins[0])
//   tx          : UART serial line, idle high
//   busy        : frame in flight or FIFO non-empty
//   overflow    : sticky "byte dropped" flag
//   fifo_level  : bytes currently queued
// master = the GPIO/system side, slave = the console.
// -----------------------------------------------------------------------------
interface gpio_uart_console_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    gpio_data;
    logic          gpio_strobe;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        output gpio_data, gpio_strobe,
        input  tx, busy, overflow, fifo_level
    );

    modport slave (
        input  gpio_data, gpio_strobe,
        output tx, busy, overflow, fifo_level
    );
endinterface

// File: rtl/console_fifo.sv
// -----------------------------------------------------------------------------
// console_fifo
// Small synchronous byte FIFO with first-word fall-through read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full unless i_pop is accepted)
//   i_data     : write data
//   i_pop      : consume the head entry (ignored when empty)
//   o_data     : head entry, valid whenever o_level != 0
//   o_level    : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module console_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            LW       = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_level == FULL_LVL);
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and the order of statements cannot create races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after it
    // was written, and leaving it out keeps it mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/gpio_uart_console.sv
// -----------------------------------------------------------------------------
// gpio_uart_console
// Captures bytes written over GPIO (data byte + toggle strobe) and serialises
// them as 8N1 UART frames for the bench console.
//   clk              : system clock, rising edge
//   power_on_reset_n : asynchronous active-low reset
//   bus (slave)      : gpio_data/gpio_strobe in; tx/busy/overflow/fifo_level out
// Parameters:
//   CLKS_PER_BIT : clocks per UART bit (2..65535)
//   FIFO_DEPTH   : byte FIFO entries (power of two, 2..16)
// Write path: 2-flop synchronisers -> strobe edge detect -> console_fifo.
// Transmit path: IDLE/START/DATA/STOP FSM with a down-counting baud counter.
// -----------------------------------------------------------------------------
module gpio_uart_console
    import f8_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 power_on_reset_n,
    gpio_uart_console_if.slave   bus
);
    localparam int            LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL    = LW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

    // Synchronisers and write-event detection
    logic       r_strobe_s1;
    logic       r_strobe_s2;
    logic       r_strobe_prev;
    logic [7:0] r_data_s1;
    logic [7:0] r_data_s2;
    logic       w_wr_event;
    logic       w_drop;
    logic       r_overflow;

    // FIFO connection
    logic          w_pop;
    logic [7:0]    w_fifo_data;
    logic [LW-1:0] w_level;
    logic          w_fifo_nonempty;

    // Transmitter
    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_bit_end;

    // -------------------------------------------------------------------------
    // Input synchronisers. Data and strobe use the same two-stage depth so the
    // byte seen with a strobe edge is the byte that was set up with it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_strobe_s1   <= 1'b0;
            r_strobe_s2   <= 1'b0;
            r_strobe_prev <= 1'b0;
            r_data_s1     <= '0;
            r_data_s2     <= '0;
        end else begin
            r_strobe_s1   <= bus.gpio_strobe;
            r_strobe_s2   <= r_strobe_s1;
            r_strobe_prev <= r_strobe_s2;
            r_data_s1     <= bus.gpio_data;
            r_data_s2     <= r_data_s1;
        end
    end

    // Either edge of the synchronised strobe is one write.
    assign w_wr_event      = r_strobe_s2 ^ r_strobe_prev;
    assign w_fifo_nonempty = (w_level != '0);
    // A write into a full FIFO is lost unless the transmitter frees a slot now.
    assign w_drop          = w_wr_event && (w_level == FULL_LVL) && !w_pop;

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (power_on_reset_n),
        .i_push  (w_wr_event),
        .i_data  (r_data_s2),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_level (w_level)
    );

    // -------------------------------------------------------------------------
    // Transmitter FSM. The baud counter runs CLKS_PER_BIT-1 down to 0 in every
    // bit; zero marks the last cycle of the current bit. w_tx_nxt is the line
    // value for the next bit so tx itself comes straight out of a flop.
    // -------------------------------------------------------------------------
    assign w_bit_end = (r_baud == '0);

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_baud_nxt    = BAUD_RELOAD;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_state_nxt   = DATA;
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = BAUD_RELOAD;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        // Bit 0 is already on the line; shift and present the next.
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    if (w_fifo_nonempty) begin
                        // Chain straight into the next start bit: no idle gap.
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_baud_nxt  = BAUD_RELOAD;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != IDLE) || w_fifo_nonempty;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = w_level;

endmodule

// File: tb/tb_gpio_uart_console.sv
// -----------------------------------------------------------------------------
// tb_gpio_uart_console
// Self-checking bench for gpio_uart_console (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A UART receiver process decodes tx and compares each frame against a
// scoreboard queue filled when bytes are written. FIFO fill/overflow behaviour
// is driven from a vector table; waveform, back-to-back and reset corner cases
// are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_gpio_uart_console;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DRAIN_LIMIT = 2000;

    logic clk;
    logic rst_n;

    gpio_uart_console_if #(.FIFO_DEPTH(DEPTH)) bus ();

    gpio_uart_console #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk              (clk),
        .power_on_reset_n (rst_n),
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;

    logic [7:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a byte and toggle the strobe; call at a negedge.
    task automatic write_byte(input logic [7:0] d);
        bus.gpio_data   = d;
        bus.gpio_strobe = ~bus.gpio_strobe;
    endtask

    // Wait until every expected frame arrived and the console went idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < DRAIN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_in_time"}, 32'(n < DRAIN_LIMIT), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // UART receiver: sample each bit mid-cell on the falling clock edge.
    // ---------------------------------------------------------------------
    int         rx_cnt;
    logic       rx_active;
    logic [7:0] rx_byte;
    logic [8:0] rx_exp;

    initial begin
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_byte   = '0;
        rx_exp    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (bus.tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                    rx_byte = {bus.tx, rx_byte[7:1]};
                end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                    check("rx_stop_bit", 32'(bus.tx), 32'd1);
                    if (sb.size() != 0) rx_exp = {1'b0, sb.pop_front()};
                    else                rx_exp = 9'h100;
                    check("rx_byte", 32'({1'b0, rx_byte}), 32'(rx_exp));
                    n_frames++;
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // FIFO fill vectors: first six = push coinciding with STOP-end pop on a
    // full FIFO; last six = fill then overflow.
    // ---------------------------------------------------------------------
    typedef struct {
        bit         drain_before;
        logic [7:0] data;
        int         gap;
        logic [2:0] exp_level;
        logic       exp_ovf;
        bit         accepted;
    } vec_t;

    vec_t vecs [12];

    int         busy_cnt;
    int         frames_mark;
    logic [7:0] s1_byte;
    logic       exp_tx;
    int         bit_idx;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'hA1, 4,  3'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'hA2, 4,  3'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'hA3, 4,  3'd2, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'hA4, 4,  3'd3, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'hA5, 25, 3'd4, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'hA6, 4,  3'd4, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h11, 4,  3'd1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h22, 4,  3'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h33, 4,  3'd2, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h44, 4,  3'd3, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h55, 4,  3'd4, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h66, 4,  3'd4, 1'b1, 1'b0};

        // ---- reset values ----
        rst_n           = 1'b0;
        bus.gpio_data   = '0;
        bus.gpio_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(bus.tx),         32'd1);
        check("rst_busy",     32'(bus.busy),       32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);
        check("rst_level",    32'(bus.fifo_level), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- single 0x55 frame, cycle-exact waveform ----
        s1_byte = 8'h55;
        write_byte(s1_byte);
        sb.push_back(s1_byte);
        repeat (3) @(negedge clk);
        check("s1_pre_start_tx", 32'(bus.tx), 32'd1);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            bit_idx = c / CPB;
            if (bit_idx == 0)      exp_tx = 1'b0;
            else if (bit_idx == 9) exp_tx = 1'b1;
            else                   exp_tx = s1_byte[bit_idx - 1];
            check($sformatf("s1_tx_cycle%0d", c), 32'(bus.tx), 32'(exp_tx));
        end
        @(negedge clk);
        check("s1_idle_tx",   32'(bus.tx),   32'd1);
        check("s1_idle_busy", 32'(bus.busy), 32'd0);

        // ---- back-to-back writes: no idle gap, busy for two frames ----
        write_byte(8'hA5);
        sb.push_back(8'hA5);
        @(negedge clk);
        write_byte(8'h3C);
        sb.push_back(8'h3C);
        busy_cnt = 0;
        for (int c = 2; c <= 84; c++) begin
            @(negedge clk);
            if (c >= 4 && c <= 83 && bus.busy) busy_cnt++;
            if (c == 43) check("s2_stop1_tx",  32'(bus.tx),   32'd1);
            if (c == 44) check("s2_start2_tx", 32'(bus.tx),   32'd0);
            if (c == 84) check("s2_busy_end",  32'(bus.busy), 32'd0);
        end
        check("s2_busy_cycles", 32'(busy_cnt), 32'd80);

        // ---- table: simultaneous push/pop when full, then overflow ----
        frames_mark = 0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].drain_before) drain($sformatf("vec%0d_drain", i));
            if (i == 6) frames_mark = n_frames;
            write_byte(vecs[i].data);
            if (vecs[i].accepted) sb.push_back(vecs[i].data);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_level", i),    32'(bus.fifo_level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_overflow", i), 32'(bus.overflow),   32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_busy", i),     32'(bus.busy),       32'd1);
            repeat (vecs[i].gap - 3) @(negedge clk);
        end
        drain("s3_drain");
        check("s3_frame_count",      32'(n_frames - frames_mark), 32'd5);
        check("s3_overflow_sticky",  32'(bus.overflow),           32'd1);
        check("s3_level_empty",      32'(bus.fifo_level),         32'd0);

        // ---- reset during DATA bit 3 ----
        write_byte(8'hB7);
        sb.push_back(8'hB7);
        @(negedge clk);
        write_byte(8'hC3);
        sb.push_back(8'hC3);
        repeat (20) @(negedge clk);
        check("s5_bit3_tx",    32'(bus.tx),         32'd0);
        check("s5_pre_level",  32'(bus.fifo_level), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("s5_rst_tx",       32'(bus.tx),         32'd1);
        check("s5_rst_level",    32'(bus.fifo_level), 32'd0);
        check("s5_rst_busy",     32'(bus.busy),       32'd0);
        check("s5_rst_overflow", 32'(bus.overflow),   32'd0);
        sb.delete();
        bus.gpio_strobe = 1'b0;
        bus.gpio_data   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frames_mark = n_frames;
        write_byte(8'h01);
        sb.push_back(8'h01);
        drain("s5_drain");
        check("s5_frame_count", 32'(n_frames - frames_mark), 32'd1);

        // ---- strobe already high at reset release gives one write ----
        rst_n           = 1'b0;
        bus.gpio_data   = 8'h7E;
        bus.gpio_strobe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames_mark = n_frames;
        sb.push_back(8'h7E);
        drain("por_strobe_drain");
        check("por_strobe_frames", 32'(n_frames - frames_mark), 32'd1);
        check("por_strobe_level",  32'(bus.fifo_level),         32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_uart_console.md
GPIO_UART_CONSOLE -- requirements
Module: gpio_uart_console

Downstream of the f8 system. Consumes GPIO pins and serialises bytes written by test programs onto an 8N1 UART line for the bench console.

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 power_on_reset_n  input  1  asynchronous, active-low reset.
REQ-005 gpio_data  input  8  byte to emit; connected to gpio0pins.
REQ-006 gpio_strobe  input  1  toggle-type write strobe; connected to gpio1pins[0].
REQ-007 tx  output  1  UART serial output, idle high.
REQ-008 busy  output  1  high while a frame is shifting or the FIFO is non-empty.
REQ-009 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-010 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes currently stored.

Function
REQ-011 gpio_strobe and gpio_data SHALL each pass through a 2-flop synchroniser; data and strobe stay cycle-aligned.
REQ-012 Any change of the synchronised strobe (either edge) SHALL be one write event.
REQ-013 On a write event, the synchronised data SHALL be pushed into the FIFO on the same edge the event is detected: 3 clk edges after the input toggle.
REQ-014 A write event while fifo_level == FIFO_DEPTH, with no pop on the same cycle, SHALL drop the byte and set overflow.
REQ-015 overflow SHALL be cleared only by reset.
REQ-016 Simultaneous push and pop with a full FIFO SHALL both succeed; fifo_level stays FIFO_DEPTH and overflow is not set.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL equal the write count minus the read count.
REQ-018 The transmitter FSM states SHALL be IDLE, START, DATA and STOP.
REQ-019 IDLE: tx = 1. When the FIFO is non-empty, pop one byte into the shift register and go to START on the next edge.
REQ-020 START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit counter tracks bits; after bit 7 go to STOP.
REQ-022 STOP: tx = 1 for CLKS_PER_BIT cycles.
REQ-023 At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-024 Each frame SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-025 The baud counter SHALL count CLKS_PER_BIT-1 down to 0 and reload on each bit boundary.
REQ-026 tx SHALL be driven from a register (glitch-free).
REQ-027 busy SHALL equal (state != IDLE) OR (fifo_level != 0).

Reset
REQ-028 While power_on_reset_n is low, outputs SHALL be: tx = 1, busy = 0, overflow = 0, fifo_level = 0; state = IDLE; pointers, counters and synchronisers = 0.
REQ-029 Reset asserted mid-frame SHALL force tx high immediately (asynchronously) and discard the frame and the FIFO contents.
REQ-030 The synchronised strobe resets to 0. After reset release, a strobe input that is already high SHALL produce one write event; test software must account for this.

Structure
REQ-031 Package f8_console_pkg SHALL hold the FSM state enum (tx_state_t) and the frame length constant (10 bits).
REQ-032 The FIFO SHALL be a sub-module console_fifo with push/pop/data/level ports; the FSM, baud counter and synchronisers live in gpio_uart_console.

Verification
REQ-033 Scenario 1, CLKS_PER_BIT=4, write 0x55 -> tx sequence is 0 (4 clks), then 1,0,1,0,1,0,1,0 (4 clks each), then 1 (4 clks); frame totals 40 clks.
REQ-034 Scenario 2, two back-to-back writes 0xA5, 0x3C -> second start bit follows first stop bit with no idle gap; busy high for 80 clks from the first start bit.
REQ-035 Scenario 3, FIFO_DEPTH=4, 6 writes spaced 4 clks -> byte 1 goes to the shifter, bytes 2-5 fill the FIFO (fifo_level=4), byte 6 dropped; overflow=1; exactly 5 frames emitted.
REQ-036 Scenario 4, a push on the same cycle as the STOP-end pop with the FIFO full -> fifo_level stays 4, overflow stays 0.
REQ-037 Scenario 5, reset asserted during DATA bit 3 -> tx=1 within the same cycle; fifo_level=0, busy=0; a subsequent write of 0x01 transmits correctly.
